// File: rtl/jk_ff.sv
// Bank of WIDTH independent positive-edge JK flip-flops with complementary outputs.
// Synchronous active-high reset loads RESET_VAL; q_bar is always the complement of the state.
module jk_ff #(
    parameter int unsigned          WIDTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    // Characteristic equation per bit: set on J, clear on K, toggle on both, hold on neither.
    always_comb begin
        state_d = (j & ~state_q) | (~k & state_q);
    end

    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
    // Reset is tested first so unknown j/k cannot leak into the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign q     = state_q;
    assign q_bar = ~state_q;

endmodule

// File: tb/tb_jk_ff.sv
// Directed self-checking bench for jk_ff: a default single-bit instance and a
// 4-bit instance with a non-zero reset value.
module tb_jk_ff;

    logic       clk;
    logic       rst;
    logic       j1, k1;
    logic       q1, qb1;
    logic [3:0] j4, k4;
    logic [3:0] q4, qb4;

    int checks = 0;
    int errors = 0;

    jk_ff u_dut1 (
        .j     (j1),
        .k     (k1),
        .clk   (clk),
        .rst   (rst),
        .q     (q1),
        .q_bar (qb1)
    );

    jk_ff #(
        .WIDTH     (4),
        .RESET_VAL (4'b1010)
    ) u_dut4 (
        .j     (j4),
        .k     (k4),
        .clk   (clk),
        .rst   (rst),
        .q     (q4),
        .q_bar (qb4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one step away from the edge, clock it, then sample 1 ns after the edge.
    task automatic step1(input logic r, input logic jj, input logic kk);
        rst = r;
        j1  = jj;
        k1  = kk;
        @(posedge clk);
        #1;
    endtask

    task automatic step4(input logic r, input logic [3:0] jj, input logic [3:0] kk);
        rst = r;
        j4  = jj;
        k4  = kk;
        @(posedge clk);
        #1;
    endtask

    task automatic expect1(input string tag, input logic exp);
        check({tag, ".q"},     {31'd0, q1},  {31'd0, exp});
        check({tag, ".q_bar"}, {31'd0, qb1}, {31'd0, ~exp});
    endtask

    task automatic expect4(input string tag, input logic [3:0] exp);
        check({tag, ".q"},     {28'd0, q4},  {28'd0, exp});
        check({tag, ".q_bar"}, {28'd0, qb4}, {28'd0, ~exp});
    endtask

    initial begin
        rst = 1'b0;
        j1  = 1'bx;
        k1  = 1'bx;
        j4  = 4'b0000;
        k4  = 4'b0000;
        @(negedge clk);

        // Reset with j/k unknown.
        step1(1'b1, 1'bx, 1'bx);
        expect1("reset", 1'b0);
        expect4("reset_w4", 4'b1010);

        // Basic operations.
        step1(1'b0, 1'b0, 1'b1); expect1("clear",  1'b0);
        step1(1'b0, 1'b1, 1'b0); expect1("set",    1'b1);
        step1(1'b0, 1'b1, 1'b1); expect1("toggle", 1'b0);
        step1(1'b0, 1'b0, 1'b0); expect1("hold0",  1'b0);
        expect4("w4_held", 4'b1010);

        // Sustained toggle from 0.
        for (int i = 0; i < 4; i++) begin
            step1(1'b0, 1'b1, 1'b1);
            expect1($sformatf("toggle_run%0d", i), (i % 2 == 0) ? 1'b1 : 1'b0);
        end

        // Hold from set, then clear.
        step1(1'b0, 1'b1, 1'b0); expect1("set2", 1'b1);
        for (int i = 0; i < 3; i++) begin
            step1(1'b0, 1'b0, 1'b0);
            expect1($sformatf("hold1_%0d", i), 1'b1);
        end
        step1(1'b0, 1'b0, 1'b1); expect1("clear2", 1'b0);

        // Reset priority over set and toggle.
        step1(1'b0, 1'b1, 1'b0); expect1("set3", 1'b1);
        step1(1'b1, 1'b1, 1'b0); expect1("rst_over_set", 1'b0);
        for (int i = 0; i < 3; i++) begin
            step1(1'b1, 1'b1, 1'b1);
            expect1($sformatf("rst_over_tog%0d", i), 1'b0);
        end
        expect4("w4_rst_again", 4'b1010);
        // First edge after reset release decodes from the reset value.
        step1(1'b0, 1'b1, 1'b1); expect1("post_rst_toggle", 1'b1);

        // 4-bit bank: mixed per-bit operations.
        step4(1'b1, 4'b1111, 4'b1111); expect4("w4_reset", 4'b1010);
        // bit0 toggle 0->1, bit1 set, bit2 clear, bit3 hold 1.
        step4(1'b0, 4'b0011, 4'b0101); expect4("w4_mixed", 4'b1011);
        // bits3,2 toggle, bits1,0 clear.
        step4(1'b0, 4'b1100, 4'b1111); expect4("w4_mixed2", 4'b0100);
        step4(1'b0, 4'b0000, 4'b0000); expect4("w4_hold", 4'b0100);
        step4(1'b0, 4'b1111, 4'b1111); expect4("w4_toggle_all", 4'b1011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
